// File: rtl/fle_cmp.sv
// Single-precision (binary32) "x1 <= x2" comparator, purely combinational.
// Denormals flush to zero, NaN operands make the compare false, and +0/-0 compare equal.
module fle_cmp (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        y
);

    logic        w_zero1;
    logic        w_zero2;
    logic        w_nan1;
    logic        w_nan2;
    logic [30:0] w_mag1;
    logic [30:0] w_mag2;
    logic        w_sgn1;
    logic        w_sgn2;
    logic        w_lt;
    logic        w_eq;
    logic        w_le;
    logic        w_ge;
    logic        w_unused;

    // clk/rstn exist only so every FPU unit shares the same port shape.
    assign w_unused = &{1'b1, clk, rstn};

    assign w_zero1 = (x1[30:23] == 8'd0);
    assign w_zero2 = (x2[30:23] == 8'd0);
    assign w_nan1  = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    assign w_nan2  = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);

    assign w_mag1  = w_zero1 ? 31'd0 : x1[30:0];
    assign w_mag2  = w_zero2 ? 31'd0 : x2[30:0];

    // A zero counts as non-negative so -0 orders exactly like +0.
    assign w_sgn1  = x1[31] & ~w_zero1;
    assign w_sgn2  = x2[31] & ~w_zero2;

    // One shared magnitude comparator; le/ge are derived from it.
    assign w_lt    = (w_mag1 < w_mag2);
    assign w_eq    = (w_mag1 == w_mag2);
    assign w_le    = w_lt | w_eq;
    assign w_ge    = ~w_lt;

    always_comb begin
        y = 1'b0;
        if (w_nan1 || w_nan2) begin
            y = 1'b0;
        end else if (w_zero1 && w_zero2) begin
            y = 1'b1;
        end else if (w_sgn1 != w_sgn2) begin
            y = w_sgn1;
        end else if (!w_sgn1) begin
            y = w_le;
        end else begin
            y = w_ge;
        end
    end

endmodule

// File: tb/tb_fle_cmp.sv
// Self-checking bench for fle_cmp: directed corner cases plus a randomized sweep
// checked against a total-order model of binary32 values.
module tb_fle_cmp;

    logic        clk;
    logic        rstn;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        y;

    int n_cmp;
    int n_bad;

    fle_cmp dut (
        .clk  (clk),
        .rstn (rstn),
        .x1   (x1),
        .x2   (x2),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s x1=%08h x2=%08h got=%b want=%b", tag, x1, x2, obs, exp);
        end
    endtask

    // Maps a value onto the real number line: zero class -> 0, others -> +/-magnitude.
    function automatic longint fp_key(input logic [31:0] v);
        longint m;
        if (v[30:23] == 8'd0) return 0;
        m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    function automatic bit fp_isnan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic ref_le(input logic [31:0] a, input logic [31:0] b);
        if (fp_isnan(a) || fp_isnan(b)) return 1'b0;
        return fp_key(a) <= fp_key(b);
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        int          k;
        v = $urandom();
        k = $urandom_range(0, 7);
        case (k)
            0: v[30:23] = 8'd0;
            1: v[30:0]  = {8'hFF, 23'd0};
            2: v[30:0]  = {8'hFF, v[22:1], 1'b1};
            3: v[30:0]  = 31'd0;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        x1 = a;
        x2 = b;
        #1;
        check(tag, y, ref_le(a, b));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        e;
    } vec_t;

    vec_t dir[14];

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          mode;

        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        x1    = 32'h3F80_0000;
        x2    = 32'h4000_0000;

        dir[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b1};
        dir[1]  = '{32'h4000_0000, 32'h3F80_0000, 1'b0};
        dir[2]  = '{32'hC000_0000, 32'hBF80_0000, 1'b1};
        dir[3]  = '{32'hBF80_0000, 32'hC000_0000, 1'b0};
        dir[4]  = '{32'h8000_0000, 32'h0000_0000, 1'b1};
        dir[5]  = '{32'h0000_0000, 32'h8000_0000, 1'b1};
        dir[6]  = '{32'h0000_0001, 32'h8000_0000, 1'b1};
        dir[7]  = '{32'h0040_0000, 32'hBF80_0000, 1'b0};
        dir[8]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1};
        dir[9]  = '{32'hFF80_0000, 32'h0000_0000, 1'b1};
        dir[10] = '{32'h7FC0_0000, 32'h3F80_0000, 1'b0};
        dir[11] = '{32'h8000_0000, 32'hC0A0_0000, 1'b0};
        dir[12] = '{32'hC0A0_0000, 32'h0000_0000, 1'b1};
        dir[13] = '{32'h7FC0_0000, 32'h7FC0_0000, 1'b0};

        // Combinational output must be valid even while reset is held.
        #2;
        check("in_reset", y, 1'b1);
        @(negedge clk);
        x1 = 32'h4000_0000;
        x2 = 32'h3F80_0000;
        #1;
        check("in_reset_swap", y, 1'b0);
        rstn = 1'b1;

        foreach (dir[i]) begin
            @(negedge clk);
            x1 = dir[i].a;
            x2 = dir[i].b;
            #1;
            check($sformatf("dir%0d", i), y, dir[i].e);
        end

        // Reset edges and clock edges must not disturb y.
        x1 = 32'hC000_0000;
        x2 = 32'hBF80_0000;
        @(posedge clk);
        rstn = 1'b0;
        #1;
        check("rst_assert", y, 1'b1);
        @(posedge clk);
        #1;
        check("rst_clk", y, 1'b1);
        rstn = 1'b1;
        #1;
        check("rst_release", y, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            a    = rnd_fp();
            mode = $urandom_range(0, 7);
            case (mode)
                0, 1, 2, 3: b = a;
                4:          b = a ^ 32'h8000_0000;
                5:          b = a + 32'd1;
                6:          b = a - 32'd1;
                default:    b = rnd_fp();
            endcase
            if ($urandom_range(0, 1) == 1) apply(a, b, "rand");
            else                           apply(b, a, "rand_sw");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
